// File: rtl/jk_stimulus_sequencer.sv
// jk_stimulus_sequencer
//   Command-driven stimulus generator for a JK flip-flop. Commands {op,len}
//   enter a small FIFO over a valid/ready handshake and are replayed
//   back-to-back on registered j/k outputs. A reference model tracks the
//   expected flip-flop state from the same j/k, and a checker flags any
//   divergence from the q read back from the flip-flop.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   cmd_valid    : command offered
//   cmd_ready    : FIFO can accept (not full)
//   cmd_op       : command as {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len      : cycles to drive the op (0 is treated as 1)
//   j, k         : registered drive to the flip-flop
//   busy         : a command is being driven or the FIFO is non-empty
//   q_in         : q fed back from the flip-flop
//   q_model      : reference-model state
//   mismatch     : sticky divergence flag
//   mismatch_cnt : saturating count of divergent cycles
module jk_stimulus_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  input  logic             q_in,
  output logic             q_model,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           jk_q, jk_d;
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [LEN_W+1:0]     mem_q [DEPTH];
  logic                 q_model_q, q_model_d;
  logic                 mismatch_q;
  logic [CNT_W-1:0]     mismatch_cnt_q;

  logic                 full, empty, push, pop;
  logic [1:0]           head_op;
  logic [LEN_W-1:0]     head_len_raw, head_len;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready depends only on registered pointers, so a pop on the same edge
  // never lets a push into a full FIFO.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  assign {head_op, head_len_raw} = mem_q[rd_ptr_q[AW-1:0]];
  assign head_len = (head_len_raw == '0) ? LEN_W'(1) : head_len_raw;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_len};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      jk_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jk_q    <= jk_d;
    end
  end

  // The last cycle of a command loads the next one directly when the FIFO
  // holds more, so consecutive commands have no gap cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jk_d    = jk_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          jk_d    = head_op;
          cnt_d   = head_len;
          state_d = DRIVE;
        end else begin
          jk_d = 2'b00;
        end
      end
      DRIVE: begin
        if (cnt_q > LEN_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!empty) begin
          pop   = 1'b1;
          jk_d  = head_op;
          cnt_d = head_len;
        end else begin
          jk_d    = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        jk_d    = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // Reference model samples the same registered j/k the flip-flop sees.
  always_comb begin
    q_model_d = q_model_q;
    case (jk_q)
      2'b01:   q_model_d = 1'b0;
      2'b10:   q_model_d = 1'b1;
      2'b11:   q_model_d = ~q_model_q;
      default: q_model_d = q_model_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_model_q      <= 1'b0;
      mismatch_q     <= 1'b0;
      mismatch_cnt_q <= '0;
    end else begin
      q_model_q <= q_model_d;
      if (q_in != q_model_q) begin
        mismatch_q <= 1'b1;
        if (mismatch_cnt_q != '1) mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
      end
    end
  end

  assign j            = jk_q[1];
  assign k            = jk_q[0];
  assign busy         = (state_q == DRIVE) || !empty;
  assign q_model      = q_model_q;
  assign mismatch     = mismatch_q;
  assign mismatch_cnt = mismatch_cnt_q;

endmodule

// File: tb/tb_jk_stimulus_sequencer.sv
module tb_jk_stimulus_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       j, k, busy, q_in, q_model, mismatch;
  logic [7:0] mismatch_cnt;

  logic       ff_q;
  logic       tie0 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural JK flip-flop standing in for the real one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= 1'b0;
    else case ({j, k})
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
  end

  assign q_in = tie0 ? 1'b0 : ff_q;

  jk_stimulus_sequencer #(.DEPTH(4), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k), .busy(busy),
    .q_in(q_in), .q_model(q_model), .mismatch(mismatch),
    .mismatch_cnt(mismatch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #10 rst = 1'b0;
    tick();
  endtask

  task automatic offer(input logic [1:0] op, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
  endtask

  logic [1:0] exp_jk [7];
  logic       exp_qm [7];
  logic [1:0] stream_ops [10];

  initial begin
    // Reset state
    do_reset();
    check("rst_jk", {j, k}, 2'b00);
    check("rst_qmodel", q_model, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_mismatch", mismatch, 1'b0);
    check("rst_mcnt", mismatch_cnt, 8'd0);

    // set/len2 then toggle/len3
    exp_jk = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    exp_qm = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    offer(2'b10, 4'd2);
    tick();                       // edge A: accepted
    check("seq_busy_after_push", busy, 1'b1);
    check("seq_no_bypass", {j, k}, 2'b00);
    offer(2'b11, 4'd3);
    tick();                       // edge A+1
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("seq_jk_%0d", i), {j, k}, exp_jk[i]);
      check($sformatf("seq_qm_%0d", i), q_model, exp_qm[i]);
      if (i == 4) check("seq_busy_last", busy, 1'b1);
      if (i == 5) check("seq_busy_drop", busy, 1'b0);
      if (i < 6) tick();
    end
    check("seq_mismatch", mismatch, 1'b0);

    // Fill FIFO behind a long hold command
    offer(2'b00, 4'd15);
    tick();                       // B
    offer(2'b10, 4'd1);
    tick();                       // B+1: hold loaded, c1 pushed
    check("fill_hold_busy", busy, 1'b1);
    offer(2'b11, 4'd1);
    tick();
    offer(2'b01, 4'd1);
    tick();
    check("fill_ready_3", cmd_ready, 1'b1);
    offer(2'b10, 4'd1);
    tick();                       // B+4: full
    check("fill_ready_full", cmd_ready, 1'b0);
    offer(2'b11, 4'd1);           // 5th command, must never enter
    tick();
    check("fill_ready_still", cmd_ready, 1'b0);
    check("fill_jk_hold", {j, k}, 2'b00);
    repeat (11) tick();           // B+16: first pop out of the full FIFO
    check("fill_ready_back", cmd_ready, 1'b1);
    check("fill_jk_c1", {j, k}, 2'b10);
    cmd_valid = 1'b0;
    tick();
    check("fill_jk_c2", {j, k}, 2'b11);
    tick();
    check("fill_jk_c3", {j, k}, 2'b01);
    tick();
    check("fill_jk_c4", {j, k}, 2'b10);
    tick();
    check("fill_jk_end", {j, k}, 2'b00);
    check("fill_busy_end", busy, 1'b0);

    // len = 0 drives one cycle
    offer(2'b10, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("len0_jk", {j, k}, 2'b10);
    check("len0_busy", busy, 1'b1);
    tick();
    check("len0_jk_end", {j, k}, 2'b00);
    check("len0_busy_end", busy, 1'b0);
    check("len0_mismatch", mismatch, 1'b0);

    // q_in tied low: divergence detection and saturation
    tie0 = 1'b1;
    do_reset();
    offer(2'b10, 4'd3);
    tick();                       // A
    cmd_valid = 1'b0;
    tick();                       // A+1: jk=10
    check("mm_qm_a1", q_model, 1'b0);
    tick();                       // A+2: model goes 1
    check("mm_qm_a2", q_model, 1'b1);
    check("mm_flag_a2", mismatch, 1'b0);
    tick();
    check("mm_flag_a3", mismatch, 1'b1);
    check("mm_cnt_a3", mismatch_cnt, 8'd1);
    tick();
    check("mm_cnt_a4", mismatch_cnt, 8'd2);
    tick();
    check("mm_cnt_a5", mismatch_cnt, 8'd3);
    check("mm_jk_a5", {j, k}, 2'b00);
    repeat (260) tick();
    check("mm_cnt_sat", mismatch_cnt, 8'hFF);
    check("mm_flag_sticky", mismatch, 1'b1);
    tie0 = 1'b0;

    // Reset in the middle of a command with two queued
    do_reset();
    check("rst2_mm_cleared", mismatch, 1'b0);
    offer(2'b11, 4'd5);
    tick();                       // A
    offer(2'b10, 4'd2);
    tick();                       // A+1: toggle loaded
    offer(2'b01, 4'd2);
    tick();                       // A+2: second toggle cycle, 2 queued
    cmd_valid = 1'b0;
    check("mid_jk_before", {j, k}, 2'b11);
    rst = 1'b1;
    #1;
    check("mid_jk", {j, k}, 2'b00);
    check("mid_qmodel", q_model, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_ready", cmd_ready, 1'b1);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("mid_idle_jk_%0d", i), {j, k}, 2'b00);
    end
    check("mid_idle_busy", busy, 1'b0);

    // Continuous push while len1 commands drain
    stream_ops = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11,
                   2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    for (int i = 0; i < 10; i++) begin
      offer(stream_ops[i], 4'd1);
      tick();
      check($sformatf("str_ready_%0d", i), cmd_ready, 1'b1);
      if (i > 0) check($sformatf("str_jk_%0d", i - 1), {j, k}, stream_ops[i - 1]);
    end
    cmd_valid = 1'b0;
    tick();
    check("str_jk_9", {j, k}, stream_ops[9]);
    tick();
    check("str_jk_end", {j, k}, 2'b00);
    check("str_busy_end", busy, 1'b0);
    check("str_mismatch", mismatch, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
